// File: rtl/mips_hazard_ctrl_if.sv
// mips_hazard_ctrl_if
//   Groups the ID-side request signals and the pipeline-control responses
//   exchanged between the pipelined MIPS core and its hazard controller.
//   master : pipeline side (drives the ID fields, consumes stall/flush/fwd)
//   slave  : hazard controller
//   Optional statistics counters appear when HAZARD_STATS_EN is defined.
interface mips_hazard_ctrl_if #(
   parameter int DEPTH = 3,
   parameter int REG_W = 5,
   parameter int SEL_W = $clog2(DEPTH + 1)
);
   // ID request
   logic             id_valid;
   logic [REG_W-1:0] id_rs_num;
   logic             id_rs_used;
   logic [REG_W-1:0] id_rt_num;
   logic             id_rt_used;
   logic [REG_W-1:0] id_rd_num;
   logic             id_reg_write;
   logic             id_is_load;
   logic             id_is_mem;
   logic             id_halt;
   logic             ex_redirect;
   logic             cache_done;
   // control response
   logic             stall_if;
   logic             stall_id;
   logic             bubble_ex;
   logic             flush_id;
   logic             freeze;
   logic [SEL_W-1:0] fwd_sel_rs;
   logic [SEL_W-1:0] fwd_sel_rt;
   logic             halted;
`ifdef HAZARD_STATS_EN
   logic [31:0]      stat_stall;
   logic [31:0]      stat_flush;
   logic [31:0]      stat_fwd;
`endif

   modport master (
      output id_valid, id_rs_num, id_rs_used, id_rt_num, id_rt_used, id_rd_num,
             id_reg_write, id_is_load, id_is_mem, id_halt, ex_redirect, cache_done,
`ifdef HAZARD_STATS_EN
      input  stat_stall, stat_flush, stat_fwd,
`endif
      input  stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_sel_rs, fwd_sel_rt, halted
   );

   modport slave (
      input  id_valid, id_rs_num, id_rs_used, id_rt_num, id_rt_used, id_rd_num,
             id_reg_write, id_is_load, id_is_mem, id_halt, ex_redirect, cache_done,
`ifdef HAZARD_STATS_EN
      output stat_stall, stat_flush, stat_fwd,
`endif
      output stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_sel_rs, fwd_sel_rt, halted
   );
endinterface

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl
//   Hazard / forwarding controller sitting beside ID. A DEPTH-entry
//   scoreboard tracks every instruction issued past ID (entry[0]=EX ...
//   entry[DEPTH-1]=writeback) and drives forwarding selects, load-use
//   stalls, cache-miss freeze, branch flush and a sticky halt.
// Ports
//   clk    : rising-edge clock
//   rst_b  : asynchronous active-low reset
//   hif    : mips_hazard_ctrl_if.slave (ID fields in, control out)
// Configuration
//   HAZARD_STATS_EN : adds 32-bit saturating stat_stall/stat_flush/stat_fwd.
module mips_hazard_ctrl #(
   parameter int DEPTH            = 3,
   parameter int REG_W            = 5,
   parameter int MEM_STAGE        = 1,
   parameter int ALU_READY_STAGE  = 1,
   parameter int LOAD_READY_STAGE = 2,
   parameter int SEL_W            = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_b,
   mips_hazard_ctrl_if.slave hif
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             wr;
      logic             load;
      logic             mem;
      logic             halt;
   } entry_t;

   entry_t           sb [DEPTH];
   logic             halt_seen;
   logic             halted;

   logic [DEPTH-1:0] hit_rs, hit_rt, rdy;
   logic [SEL_W-1:0] sel_rs, sel_rt;
   logic             haz_rs, haz_rt;
   logic             hazard, freeze, load_use, issue;
   entry_t           id_entry;

   // Per-entry match and readiness; register 0 never creates a dependency.
   for (genvar k = 0; k < DEPTH; k++) begin : g_ent
      assign hit_rs[k] = sb[k].valid & sb[k].wr & (sb[k].rd == hif.id_rs_num) &
                         (hif.id_rs_num != '0);
      assign hit_rt[k] = sb[k].valid & sb[k].wr & (sb[k].rd == hif.id_rt_num) &
                         (hif.id_rt_num != '0);
      assign rdy[k]    = sb[k].load ? (k >= LOAD_READY_STAGE) : (k >= ALU_READY_STAGE);
   end

   // Scan oldest to youngest so the youngest producer overwrites older ones.
   // A youngest producer that is not ready blocks forwarding from older ones.
   always_comb begin
      sel_rs = '0;
      sel_rt = '0;
      haz_rs = 1'b0;
      haz_rt = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (hit_rs[k]) begin
            sel_rs = rdy[k] ? SEL_W'(k + 1) : '0;
            haz_rs = ~rdy[k];
         end
         if (hit_rt[k]) begin
            sel_rt = rdy[k] ? SEL_W'(k + 1) : '0;
            haz_rt = ~rdy[k];
         end
      end
   end

   assign hazard   = (hif.id_rs_used & haz_rs) | (hif.id_rt_used & haz_rt);
   assign freeze   = sb[MEM_STAGE].valid & sb[MEM_STAGE].mem & ~hif.cache_done;
   // A redirect outranks the hazard: the wrong-path ID is dropped anyway.
   assign load_use = ~freeze & ~hif.ex_redirect & hif.id_valid & hazard;
   // Once a halt has issued, everything younger is squashed instead of issued.
   assign issue    = ~freeze & ~hif.ex_redirect & hif.id_valid & ~hazard & ~halt_seen;

   assign id_entry = '{valid: 1'b1,
                       rd:    hif.id_rd_num,
                       wr:    hif.id_reg_write,
                       load:  hif.id_is_load,
                       mem:   hif.id_is_mem,
                       halt:  hif.id_halt};

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
         halt_seen <= 1'b0;
         halted    <= 1'b0;
      end else if (!freeze) begin
         for (int k = DEPTH - 1; k > 0; k--) sb[k] <= sb[k-1];
         sb[0] <= issue ? id_entry : '0;
         if (sb[DEPTH-1].valid && sb[DEPTH-1].halt) halted <= 1'b1;
         if (issue && hif.id_halt) halt_seen <= 1'b1;
      end
   end

   // Freeze wins over everything and leaves ex_redirect pending.
   assign hif.stall_if   = freeze | load_use | halt_seen;
   assign hif.stall_id   = freeze | load_use;
   assign hif.bubble_ex  = ~freeze & (hif.ex_redirect | load_use | halt_seen);
   assign hif.flush_id   = ~freeze & hif.ex_redirect;
   assign hif.freeze     = freeze;
   assign hif.fwd_sel_rs = hif.id_rs_used ? sel_rs : '0;
   assign hif.fwd_sel_rt = hif.id_rt_used ? sel_rt : '0;
   assign hif.halted     = halted;

`ifdef HAZARD_STATS_EN
   logic [31:0] stat_stall, stat_flush, stat_fwd;
   logic        fwd_any;

   assign fwd_any = (hif.fwd_sel_rs != '0) | (hif.fwd_sel_rt != '0);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stat_stall <= '0;
         stat_flush <= '0;
         stat_fwd   <= '0;
      end else if (!halted) begin
         if (load_use && stat_stall != '1)          stat_stall <= stat_stall + 32'd1;
         if (hif.flush_id && stat_flush != '1)      stat_flush <= stat_flush + 32'd1;
         if (issue && fwd_any && stat_fwd != '1)    stat_fwd   <= stat_fwd + 32'd1;
      end
   end

   assign hif.stat_stall = stat_stall;
   assign hif.stat_flush = stat_flush;
   assign hif.stat_fwd   = stat_fwd;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl
//   Directed scenarios followed by a randomized run, each cycle compared
//   against a queue-based model of the in-flight instruction list.
module tb_mips_hazard_ctrl;
   localparam int DEPTH = 3;
   localparam int REG_W = 5;
   localparam int MS    = 1;
   localparam int ARS   = 1;
   localparam int LRS   = 2;

   logic clk   = 1'b0;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   mips_hazard_ctrl_if #(.DEPTH(DEPTH), .REG_W(REG_W)) hif ();

   mips_hazard_ctrl #(
      .DEPTH(DEPTH), .REG_W(REG_W), .MEM_STAGE(MS),
      .ALU_READY_STAGE(ARS), .LOAD_READY_STAGE(LRS)
   ) dut (
      .clk(clk), .rst_b(rst_b), .hif(hif)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {bit v; int rd; bit wr, ld, mem, hl;} rec_t;
   rec_t q[$];            // q[k] is the instruction k stages past ID
   bit   halted_m, hs_m;
   bit   e_frz, e_sif, e_sid, e_bub, e_fl, e_iss, e_lu;
   int   e_srs, e_srt;
`ifdef HAZARD_STATS_EN
   int unsigned st_m, fl_m, fw_m;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void lookup(input int r, input bit used, output int sel, output bit haz);
      sel = 0;
      haz = 1'b0;
      if (!used || r == 0) return;
      for (int k = 0; k < q.size(); k++) begin
         if (q[k].v && q[k].wr && q[k].rd == r) begin
            if (k >= (q[k].ld ? LRS : ARS)) sel = k + 1;
            else haz = 1'b1;
            return;
         end
      end
   endfunction

   task automatic set_id(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rd, input bit wr, input bit ld, input bit mem, input bit hl);
      hif.id_valid     = v;
      hif.id_rs_num    = REG_W'(rs);
      hif.id_rs_used   = rsu;
      hif.id_rt_num    = REG_W'(rt);
      hif.id_rt_used   = rtu;
      hif.id_rd_num    = REG_W'(rd);
      hif.id_reg_write = wr;
      hif.id_is_load   = ld;
      hif.id_is_mem    = mem;
      hif.id_halt      = hl;
   endtask

   task automatic model_reset();
      rec_t e;
      e = '{default: 0};
      q.delete();
      for (int k = 0; k < DEPTH; k++) q.push_back(e);
      halted_m = 1'b0;
      hs_m     = 1'b0;
`ifdef HAZARD_STATS_EN
      st_m = 0; fl_m = 0; fw_m = 0;
`endif
   endtask

   // Compute expectations from the model and compare mid-cycle.
   task automatic sample();
      bit hrs, hrt, hz;
      @(negedge clk);
      lookup(int'(hif.id_rs_num), hif.id_rs_used, e_srs, hrs);
      lookup(int'(hif.id_rt_num), hif.id_rt_used, e_srt, hrt);
      hz    = hrs | hrt;
      e_frz = q[MS].v && q[MS].mem && !hif.cache_done;
      e_lu  = 1'b0;
      e_fl  = 1'b0;
      if (e_frz) begin
         e_sif = 1; e_sid = 1; e_bub = 0;
      end else if (hif.ex_redirect) begin
         e_sif = hs_m; e_sid = 0; e_bub = 1; e_fl = 1;
      end else if (hif.id_valid && hz) begin
         e_sif = 1; e_sid = 1; e_bub = 1; e_lu = 1;
      end else begin
         e_sif = hs_m; e_sid = 0; e_bub = hs_m;
      end
      e_iss = !e_frz && !hif.ex_redirect && hif.id_valid && !hz && !hs_m;
      chk("stall_if",   32'(hif.stall_if),   32'(e_sif));
      chk("stall_id",   32'(hif.stall_id),   32'(e_sid));
      chk("bubble_ex",  32'(hif.bubble_ex),  32'(e_bub));
      chk("flush_id",   32'(hif.flush_id),   32'(e_fl));
      chk("freeze",     32'(hif.freeze),     32'(e_frz));
      chk("fwd_sel_rs", 32'(hif.fwd_sel_rs), e_srs);
      chk("fwd_sel_rt", 32'(hif.fwd_sel_rt), e_srt);
      chk("halted",     32'(hif.halted),     32'(halted_m));
`ifdef HAZARD_STATS_EN
      chk("stat_stall", hif.stat_stall, st_m);
      chk("stat_flush", hif.stat_flush, fl_m);
      chk("stat_fwd",   hif.stat_fwd,   fw_m);
`endif
   endtask

   // Step the model across the clock edge using the inputs sampled above.
   task automatic adv();
      rec_t n, o;
      @(posedge clk);
      #1;
`ifdef HAZARD_STATS_EN
      if (!halted_m) begin
         if (e_lu && st_m != 32'hFFFF_FFFF) st_m++;
         if (e_fl && fl_m != 32'hFFFF_FFFF) fl_m++;
         if (e_iss && (e_srs != 0 || e_srt != 0) && fw_m != 32'hFFFF_FFFF) fw_m++;
      end
`endif
      if (!e_frz) begin
         n = '{default: 0};
         if (e_iss) begin
            n.v  = 1'b1;
            n.rd = int'(hif.id_rd_num);
            n.wr = hif.id_reg_write;
            n.ld = hif.id_is_load;
            n.mem = hif.id_is_mem;
            n.hl = hif.id_halt;
         end
         q.push_front(n);
         o = q.pop_back();
         if (o.v && o.hl) halted_m = 1'b1;
         if (e_iss && hif.id_halt) hs_m = 1'b1;
      end
   endtask

   // Assert reset between edges; outputs must drop without a clock.
   task automatic do_reset();
      rst_b = 1'b0;
      #1;
      chk("rst_stall_if",  32'(hif.stall_if),   0);
      chk("rst_stall_id",  32'(hif.stall_id),   0);
      chk("rst_bubble_ex", 32'(hif.bubble_ex),  0);
      chk("rst_flush_id",  32'(hif.flush_id),   0);
      chk("rst_freeze",    32'(hif.freeze),     0);
      chk("rst_fwd_rs",    32'(hif.fwd_sel_rs), 0);
      chk("rst_fwd_rt",    32'(hif.fwd_sel_rt), 0);
      chk("rst_halted",    32'(hif.halted),     0);
      model_reset();
      @(posedge clk);
      #1;
      rst_b = 1'b1;
   endtask

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      hif.ex_redirect = 1'b0;
      hif.cache_done  = 1'b1;
      #2;
      do_reset();

      // lw $2 then add $3,$2,$4: stall until the load reaches entry[2]
      set_id(1, 1, 1, 0, 0, 2, 1, 1, 1, 0); sample(); chk("lw_no_stall", 32'(hif.stall_id), 0); adv();
      set_id(1, 2, 1, 4, 1, 3, 1, 0, 0, 0); sample();
      chk("lu_stall_if", 32'(hif.stall_if), 1); chk("lu_bubble", 32'(hif.bubble_ex), 1); adv();
      sample(); chk("lu_stall_e1", 32'(hif.stall_id), 1); adv();
      sample(); chk("lu_fwd_rs", 32'(hif.fwd_sel_rs), 3); chk("lu_release", 32'(hif.stall_id), 0); adv();

      // add $5 ; nop ; sub $6,$5,$5: forwarded from entry[1]
      set_id(1, 1, 1, 1, 1, 5, 1, 0, 0, 0); sample(); adv();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample(); adv();
      set_id(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); sample();
      chk("alu_fwd_rs", 32'(hif.fwd_sel_rs), 2); chk("alu_fwd_rt", 32'(hif.fwd_sel_rt), 2);
      chk("alu_no_stall", 32'(hif.stall_id), 0); adv();

      // write $0 then read $0
      set_id(1, 1, 1, 1, 1, 0, 1, 0, 0, 0); sample(); adv();
      set_id(1, 0, 1, 0, 1, 8, 1, 0, 0, 0); sample();
      chk("r0_fwd_rs", 32'(hif.fwd_sel_rs), 0); chk("r0_fwd_rt", 32'(hif.fwd_sel_rt), 0);
      chk("r0_no_stall", 32'(hif.stall_id), 0); adv();

      // store reaches MEM_STAGE, cache busy 4 cycles with a pending redirect
      set_id(1, 1, 1, 2, 1, 0, 0, 0, 1, 0); sample(); adv();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample(); adv();
      hif.cache_done = 1'b0; hif.ex_redirect = 1'b1;
      set_id(1, 9, 1, 9, 1, 10, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         sample(); chk("frz_freeze", 32'(hif.freeze), 1); chk("frz_no_flush", 32'(hif.flush_id), 0); adv();
      end
      hif.cache_done = 1'b1;
      sample(); chk("rel_flush", 32'(hif.flush_id), 1); chk("rel_bubble", 32'(hif.bubble_ex), 1);
      chk("rel_freeze", 32'(hif.freeze), 0); adv();
      hif.ex_redirect = 1'b0;

      // two writers of $7: youngest (entry[0]) is not ready, so stall
      set_id(1, 1, 1, 1, 1, 7, 1, 0, 0, 0); sample(); adv();
      sample(); adv();
      set_id(1, 7, 1, 0, 0, 11, 1, 0, 0, 0); sample();
      chk("dup_stall", 32'(hif.stall_id), 1); chk("dup_fwd_rs", 32'(hif.fwd_sel_rs), 0); adv();
      sample(); chk("dup_fwd_rs2", 32'(hif.fwd_sel_rs), 2); adv();

      // randomized traffic, no halts
      for (int i = 0; i < 400; i++) begin
         bit ld, mem, wr;
         ld  = ($urandom_range(0, 3) == 0);
         mem = ld | ($urandom_range(0, 5) == 0);
         wr  = ld | bit'($urandom_range(0, 1));
         set_id(bit'($urandom_range(0, 4) != 0), $urandom_range(0, 7), bit'($urandom_range(0, 1)),
                $urandom_range(0, 7), bit'($urandom_range(0, 1)), $urandom_range(0, 7), wr, ld, mem, 0);
         hif.cache_done  = ($urandom_range(0, 3) != 0);
         hif.ex_redirect = ($urandom_range(0, 9) == 0);
         sample(); adv();
      end

      // drain, then syscall
      hif.cache_done = 1'b1; hif.ex_redirect = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i <= DEPTH; i++) begin sample(); adv(); end
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); sample(); chk("halt_issue_sif", 32'(hif.stall_if), 0); adv();
      set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
      for (int i = 1; i <= DEPTH + 1; i++) begin
         sample();
         chk("halt_sif", 32'(hif.stall_if), 1);
         chk("halt_halted", 32'(hif.halted), (i > DEPTH) ? 1 : 0);
         adv();
      end

      // reset mid-run with a live ID instruction
      set_id(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_id(1, $urandom_range(0, 3), 1, $urandom_range(0, 3), 1, $urandom_range(0, 3), 1,
                bit'($urandom_range(0, 1)), 0, 0);
         sample(); adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
